// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution line-buffer controller.
package conv_pkg;

  localparam int CONV_K = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    PADC = 3'd2,
    PADR = 3'd3,
    DONE = 3'd4
  } conv_lb_ctrl_st_t;

  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } conv_bdr_t;

  // Line-buffer write index rotates through the CONV_K buffers.
  function automatic logic [1:0] wsel_next(input logic [1:0] wsel);
    if (wsel == 2'(CONV_K - 1)) begin
      return 2'd0;
    end else begin
      return wsel + 2'd1;
    end
  endfunction

endpackage

// File: rtl/conv_lb_ctrl_geom.sv
// Frame width latch plus optional geometry error checks (built when CONV_LB_CTRL_ERR_EN is defined).
module conv_lb_ctrl_geom #(
  parameter int W_MAX = 1024,
  parameter int CW    = 11
`ifdef CONV_LB_CTRL_ERR_EN
  ,
  parameter int H_MAX = 1024,
  parameter int RW    = 11
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_i,
  input  logic          eol_i,
  input  logic          clr_i,
  input  logic [CW-1:0] col_i,
`ifdef CONV_LB_CTRL_ERR_EN
  input  logic          eof_i,
  input  logic [RW-1:0] row_i,
  input  logic          padc_adv_i,
  input  logic          eof_seen_i,
`endif
  output logic [CW-1:0] w_o,
  output logic          err_o
);

  logic [CW-1:0] w_q, w_d;
  logic          w_vld_q, w_vld_d;
`ifdef CONV_LB_CTRL_ERR_EN
  logic          err_q, err_d;
  logic          chk_s;
`endif

  // Width is taken from the first end-of-line of a frame and held until the frame ends.
  always_comb begin
    w_d     = w_q;
    w_vld_d = w_vld_q;
    if (clr_i) begin
      w_d     = CW'(0);
      w_vld_d = 1'b0;
    end else if (acc_i && eol_i && !w_vld_q) begin
      w_d     = col_i + CW'(1);
      w_vld_d = 1'b1;
    end else begin
      w_d     = w_q;
      w_vld_d = w_vld_q;
    end
`ifdef CONV_LB_CTRL_ERR_EN
    chk_s = (acc_i & eol_i & w_vld_q & (col_i != (w_q - CW'(1))))
          | (acc_i & ~eol_i & (col_i == CW'(W_MAX - 1)))
          | (padc_adv_i & ~eof_seen_i & (row_i == RW'(H_MAX - 1)))
          | (acc_i & eof_i & ~eol_i);
    err_d = err_q | chk_s;
`endif
  end

  // Width latch and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= CW'(0);
      w_vld_q <= 1'b0;
`ifdef CONV_LB_CTRL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      w_q     <= w_d;
      w_vld_q <= w_vld_d;
`ifdef CONV_LB_CTRL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign w_o = w_q;
`ifdef CONV_LB_CTRL_ERR_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/conv_lb_ctrl.sv
// Line-buffer sequencing controller: raster tracking, zero-pad insertion, window and border flags.
// Geometry error checking is built only when CONV_LB_CTRL_ERR_EN is defined.
module conv_lb_ctrl
  import conv_pkg::*;
#(
  parameter int W_MAX = 1024,
  parameter int H_MAX = 1024,
  localparam int CW = $clog2(W_MAX + 1),
  localparam int RW = $clog2(H_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pixel_vld_i,
  input  logic          pixel_eol_i,
  input  logic          pixel_eof_i,
  input  logic          stall_i,
  output logic          stall_o,
  output logic          lb_vld_o,
  output logic          lb_pad_o,
  output logic [1:0]    lb_wsel_o,
  output logic          win_vld_o,
  output logic [RW-1:0] win_row_o,
  output logic [CW-1:0] win_col_o,
  output logic [3:0]    bdr_o,
  output logic          frame_done_o,
  output logic          err_o
);

  conv_lb_ctrl_st_t st_q, st_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    wsel_q, wsel_d;
  logic          eof_seen_q, eof_seen_d;

  logic          lb_vld_q, lb_vld_d;
  logic          lb_pad_q, lb_pad_d;
  logic [1:0]    lb_wsel_q, lb_wsel_d;
  logic          win_vld_q, win_vld_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  conv_bdr_t     bdr_q, bdr_d;
  logic          frame_done_q, frame_done_d;

  logic          pad_st_s, acc_s, adv_s, win_s;
  logic [CW-1:0] w_s;
  logic          err_s;

  assign pad_st_s = (st_q == PADC) || (st_q == PADR);
  assign stall_o  = stall_i | pad_st_s | (st_q == DONE);
  assign acc_s    = pixel_vld_i & ~stall_o;
  assign adv_s    = acc_s | (pad_st_s & ~stall_i);
  // A window is complete once the advance is at least one row and one column in.
  assign win_s    = adv_s & (row_q != RW'(0)) & (col_q != CW'(0));

`ifdef CONV_LB_CTRL_ERR_EN
  logic padc_adv_s;
  assign padc_adv_s = adv_s & (st_q == PADC);
`endif

  conv_lb_ctrl_geom #(
    .W_MAX (W_MAX),
    .CW    (CW)
`ifdef CONV_LB_CTRL_ERR_EN
    ,
    .H_MAX (H_MAX),
    .RW    (RW)
`endif
  ) u_geom (
    .clk        (clk),
    .rst        (rst),
    .acc_i      (acc_s),
    .eol_i      (pixel_eol_i),
    .clr_i      (st_q == DONE),
    .col_i      (col_q),
`ifdef CONV_LB_CTRL_ERR_EN
    .eof_i      (pixel_eof_i),
    .row_i      (row_q),
    .padc_adv_i (padc_adv_s),
    .eof_seen_i (eof_seen_q),
`endif
    .w_o        (w_s),
    .err_o      (err_s)
  );

  // Sequencing and registered-output next values; position only moves on an advance.
  always_comb begin
    st_d       = st_q;
    row_d      = row_q;
    col_d      = col_q;
    wsel_d     = wsel_q;
    eof_seen_d = eof_seen_q;
    case (st_q)
      IDLE, ROW: begin
        if (acc_s) begin
          col_d      = col_q + CW'(1);
          eof_seen_d = eof_seen_q | pixel_eof_i;
          st_d       = pixel_eol_i ? PADC : ROW;
        end else begin
          st_d = st_q;
        end
      end
      PADC: begin
        if (adv_s) begin
          col_d  = CW'(0);
          row_d  = row_q + RW'(1);
          wsel_d = wsel_next(wsel_q);
          st_d   = eof_seen_q ? PADR : ROW;
        end else begin
          st_d = st_q;
        end
      end
      PADR: begin
        if (adv_s && (col_q == w_s)) begin
          st_d = DONE;
        end else if (adv_s) begin
          col_d = col_q + CW'(1);
        end else begin
          st_d = st_q;
        end
      end
      DONE: begin
        row_d      = RW'(0);
        col_d      = CW'(0);
        wsel_d     = 2'd0;
        eof_seen_d = 1'b0;
        st_d       = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase

    lb_vld_d     = adv_s;
    lb_pad_d     = adv_s & pad_st_s;
    lb_wsel_d    = wsel_q;
    win_vld_d    = win_s;
    frame_done_d = (st_q == DONE);
    if (win_s) begin
      win_row_d    = row_q - RW'(1);
      win_col_d    = col_q - CW'(1);
      bdr_d.top    = (row_q == RW'(1));
      bdr_d.bottom = (st_q == PADR);
      bdr_d.left   = (col_q == CW'(1));
      bdr_d.right  = (st_q == PADC) || ((st_q == PADR) && (col_q == w_s));
    end else begin
      win_row_d = RW'(0);
      win_col_d = CW'(0);
      bdr_d     = 4'b0000;
    end
  end

  // State, position and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      row_q        <= RW'(0);
      col_q        <= CW'(0);
      wsel_q       <= 2'd0;
      eof_seen_q   <= 1'b0;
      lb_vld_q     <= 1'b0;
      lb_pad_q     <= 1'b0;
      lb_wsel_q    <= 2'd0;
      win_vld_q    <= 1'b0;
      win_row_q    <= RW'(0);
      win_col_q    <= CW'(0);
      bdr_q        <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wsel_q       <= wsel_d;
      eof_seen_q   <= eof_seen_d;
      lb_vld_q     <= lb_vld_d;
      lb_pad_q     <= lb_pad_d;
      lb_wsel_q    <= lb_wsel_d;
      win_vld_q    <= win_vld_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      bdr_q        <= bdr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lb_vld_o     = lb_vld_q;
  assign lb_pad_o     = lb_pad_q;
  assign lb_wsel_o    = lb_wsel_q;
  assign win_vld_o    = win_vld_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign bdr_o        = bdr_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_s;

endmodule

// File: tb/tb_conv_lb_ctrl.sv
// Self-checking bench for conv_lb_ctrl: frame table plus reset, stall and error sequences.
module tb_conv_lb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_vld_i = 1'b0, pixel_eol_i = 1'b0, pixel_eof_i = 1'b0, stall_i = 1'b0;
  logic        stall_o, lb_vld_o, lb_pad_o, win_vld_o, frame_done_o, err_o;
  logic [1:0]  lb_wsel_o;
  logic [10:0] win_row_o, win_col_o;
  logic [3:0]  bdr_o;

`ifdef CONV_LB_CTRL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  conv_lb_ctrl dut (
    .clk(clk), .rst(rst), .pixel_vld_i(pixel_vld_i), .pixel_eol_i(pixel_eol_i),
    .pixel_eof_i(pixel_eof_i), .stall_i(stall_i), .stall_o(stall_o), .lb_vld_o(lb_vld_o),
    .lb_pad_o(lb_pad_o), .lb_wsel_o(lb_wsel_o), .win_vld_o(win_vld_o), .win_row_o(win_row_o),
    .win_col_o(win_col_o), .bdr_o(bdr_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int w; int stall_at; int stall_len;
    int exp_px; int exp_pad; int exp_win;
  } frame_vec_t;

  typedef struct {
    logic pad; logic [1:0] wsel; logic win; int row; int col; logic [3:0] bdr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_err = 0;
  int   px_cnt, pad_cnt, win_cnt, done_cnt;
  int   cyc = 0, last_vld_cyc = 0;
  logic sb_en = 1'b1;
  logic stall_edge;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected advance at input coordinate (r,c) of an h x w frame.
  task automatic push_exp(input int r, input int c, input int h, input int w);
    exp_t e;
    e.pad  = (c == w) || (r == h);
    e.wsel = 2'(r % 3);
    e.win  = (r >= 1) && (c >= 1);
    e.row  = r - 1;
    e.col  = c - 1;
    e.bdr  = {r == 1, r == h, c == 1, c == w};
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      stall_edge = stall_i;
      @(negedge clk);
      cyc++;
      if (stall_edge) chk("no_adv_in_stall", lb_vld_o, 0);
      if (lb_vld_o) begin
        last_vld_cyc = cyc;
        if (lb_pad_o) pad_cnt++; else px_cnt++;
        if (win_vld_o) win_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL sb_underflow: unexpected advance (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("adv_pad", lb_pad_o, e.pad);
            chk("adv_wsel", lb_wsel_o, e.wsel);
            chk("win_vld", win_vld_o, e.win);
            if (e.win) begin
              chk("win_row", win_row_o, e.row);
              chk("win_col", win_col_o, e.col);
              chk("win_bdr", bdr_o, e.bdr);
            end
          end
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        chk("done_latency", cyc - last_vld_cyc, 1);
      end
    end
  endtask

  // Present one pixel at a negedge and return at the negedge after it is accepted.
  task automatic send_px(input logic eol, input logic eof);
    int guard = 0;
    pixel_vld_i = 1'b1; pixel_eol_i = eol; pixel_eof_i = eof;
    #1;
    while (stall_o && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: pixel not accepted after %0d cycles", guard);
    end
    @(negedge clk);
    pixel_vld_i = 1'b0; pixel_eol_i = 1'b0; pixel_eof_i = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    int guard = 0;
    logic eol, eof;
    px_cnt = 0; pad_cnt = 0; win_cnt = 0; done_cnt = 0;
    for (int r = 0; r < v.h; r++) begin
      for (int c = 0; c < v.w; c++) begin
        eol = (c == v.w - 1);
        eof = eol && (r == v.h - 1);
        push_exp(r, c, v.h, v.w);
        if (eol) push_exp(r, v.w, v.h, v.w);
        if (eof) for (int k = 0; k <= v.w; k++) push_exp(v.h, k, v.h, v.w);
        send_px(eol, eof);
      end
    end
    if (v.stall_at > 0) begin
      repeat (v.stall_at) @(negedge clk);
      stall_i = 1'b1;
      repeat (v.stall_len) @(negedge clk);
      stall_i = 1'b0;
    end
    while (done_cnt == 0 && guard < 200) begin
      @(negedge clk); guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: frame %0dx%0d never finished", v.h, v.w);
    end
    repeat (3) @(negedge clk);
    chk("px_count", px_cnt, v.exp_px);
    chk("pad_count", pad_cnt, v.exp_pad);
    chk("win_count", win_cnt, v.exp_win);
    chk("done_pulses", done_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall_i = 1'b0;
    pixel_vld_i = 1'b0; pixel_eol_i = 1'b0; pixel_eof_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    frame_vec_t vecs[5];
    frame_vec_t v2x2;
    logic stop;
    vecs[0] = '{h: 3, w: 3, stall_at: 0, stall_len: 0, exp_px: 9, exp_pad: 7, exp_win: 9};
    vecs[1] = '{h: 1, w: 1, stall_at: 0, stall_len: 0, exp_px: 1, exp_pad: 3, exp_win: 1};
    vecs[2] = '{h: 1, w: 3, stall_at: 0, stall_len: 0, exp_px: 3, exp_pad: 5, exp_win: 3};
    vecs[3] = '{h: 2, w: 4, stall_at: 3, stall_len: 5, exp_px: 8, exp_pad: 7, exp_win: 8};
    vecs[4] = '{h: 4, w: 2, stall_at: 0, stall_len: 0, exp_px: 8, exp_pad: 7, exp_win: 8};
    v2x2    = '{h: 2, w: 2, stall_at: 0, stall_len: 0, exp_px: 4, exp_pad: 5, exp_win: 4};

    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_lb_vld", lb_vld_o, 0);
    chk("rst_lb_pad", lb_pad_o, 0);
    chk("rst_wsel", lb_wsel_o, 0);
    chk("rst_win_vld", win_vld_o, 0);
    chk("rst_win_pos", {win_row_o, win_col_o}, 0);
    chk("rst_bdr", bdr_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_err", err_o, 0);
    stall_i = 1'b1; #1;
    chk("rst_stall_follow_hi", stall_o, 1);
    stall_i = 1'b0; #1;
    chk("rst_stall_follow_lo", stall_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of row 2 of a 4x4 frame, then a clean 2x2 frame.
    done_cnt = 0;
    stop = 1'b0;
    for (int r = 0; r < 4 && !stop; r++) begin
      for (int c = 0; c < 4 && !stop; c++) begin
        if (r == 2 && c == 2) begin
          stop = 1'b1;
        end else begin
          push_exp(r, c, 4, 4);
          if (c == 3) push_exp(r, 4, 4, 4);
          send_px(c == 3, 1'b0);
        end
      end
    end
    @(negedge clk);
    chk("partial_sb_drained", exp_q.size(), 0);
    reset_dut();
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", done_cnt, 0);
    chk("idle_no_adv_after_rst", lb_vld_o, 0);
    run_frame(v2x2);
    repeat (2) @(negedge clk);

    // Width mismatch on row 1: W=4 then eol at col 2.
    sb_en = 1'b0;
    for (int c = 0; c < 4; c++) send_px(c == 3, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b0, 1'b0);
    chk("err_before_bad_eol", err_o, 0);
    send_px(1'b1, 1'b0);
    chk("err_set", err_o, ERR_EXP);
    repeat (5) @(negedge clk);
    chk("err_hold", err_o, ERR_EXP);
    rst = 1'b1;
    @(negedge clk);
    chk("err_clr_by_rst", err_o, 0);
    reset_dut();
    sb_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
